// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//
// Purpose:
//   Operand forwarding and load-use hazard control for a classic 5-stage
//   pipeline. It serves NUM_SRC source operands per instruction and sits
//   between the ID/EX, EX/MEM and MEM/WB buffers.
//   - Forwarding is purely combinational and has no latency. For each
//     operand it picks the EX/MEM result, the MEM/WB data, or the
//     register-file value.
//   - A load-use hazard holds PC and IF/ID and bubbles ID/EX for
//     LOAD_STALL_CYC cycles. A small IDLE/STALL FSM with a down-counter
//     tracks the sequence.
//
// Parameters:
//   REG_ADDR_W      register address width (register 0 is hardwired zero)
//   DATA_W          operand/result data width
//   NUM_SRC         source operands per instruction (1..4)
//   LOAD_STALL_CYC  bubble cycles per load-use hazard (1..7)
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              branch/jump flush, aborts any stall sequence
//   if_id_src_addr     source registers of the instruction in ID
//   id_ex_src_addr     source registers of the instruction in EX
//   id_ex_src_data     register-file operand values in EX
//   id_ex_dst_addr     destination of the instruction in EX
//   id_ex_mem_read     instruction in EX is a load
//   ex_mem_*           destination, write enable and ALU result in EX/MEM
//   mem_wb_*           destination, write enable and write-back data in MEM/WB
//   fwd_sel            per operand: 00 reg file, 10 EX/MEM, 01 MEM/WB
//   fwd_data           per-operand forwarded value
//   stall              hold PC and IF/ID
//   bubble             zero the ID/EX control signals (insert a NOP)
//   busy               FSM is in STALL
//
// Optional feature (macro FWD_STATS_EN):
//   Adds the saturating counters fwd_count and stall_count. fwd_count adds
//   the number of forwarded operands on every non-bubble cycle. stall_count
//   adds one on every stall cycle.

module hazard_forward_ctrl #(
  parameter int REG_ADDR_W     = 4,
  parameter int DATA_W         = 16,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] if_id_src_addr,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]     id_ex_src_data,
  input  logic [REG_ADDR_W-1:0]         id_ex_dst_addr,
  input  logic                          id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_mem_dst_addr,
  input  logic                          ex_mem_reg_write,
  input  logic [DATA_W-1:0]             ex_mem_result,
  input  logic [REG_ADDR_W-1:0]         mem_wb_dst_addr,
  input  logic                          mem_wb_reg_write,
  input  logic [DATA_W-1:0]             mem_wb_data,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]     fwd_data,
  output logic                          stall,
  output logic                          bubble,
  output logic                          busy
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]                   fwd_count,
  output logic [15:0]                   stall_count
`endif
);

  typedef enum logic [0:0] {IDLE, STALL} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(LOAD_STALL_CYC - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] src_addr;
  logic                  ex_mem_valid;
  logic                  mem_wb_valid;
  logic                  hz;

  // A stage can forward only if it writes a real (non-zero) register.
  assign ex_mem_valid = ex_mem_reg_write && (ex_mem_dst_addr != '0);
  assign mem_wb_valid = mem_wb_reg_write && (mem_wb_dst_addr != '0);

  // EX/MEM is checked first because it holds the youngest value.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    src_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_addr = id_ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      if (ex_mem_valid && (ex_mem_dst_addr == src_addr)) begin
        fwd_sel[i*2 +: 2]       = 2'b10;
        fwd_data[i*DATA_W +: DATA_W] = ex_mem_result;
      end else if (mem_wb_valid && (mem_wb_dst_addr == src_addr)) begin
        fwd_sel[i*2 +: 2]       = 2'b01;
        fwd_data[i*DATA_W +: DATA_W] = mem_wb_data;
      end else begin
        fwd_sel[i*2 +: 2]       = 2'b00;
        fwd_data[i*DATA_W +: DATA_W] = id_ex_src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The load in EX cannot forward its data to the instruction in ID in
  // time, so any ID source that matches the load destination is a hazard.
  always_comb begin
    hz = 1'b0;
    if (id_ex_mem_read && (id_ex_dst_addr != '0)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (if_id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_dst_addr) begin
          hz = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first bubble is raised combinationally in IDLE. STALL covers the
  // remaining LOAD_STALL_CYC-1 cycles. A flush overrides everything,
  // including a hazard seen in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = STALL;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        STALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt_q == 3'd1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign busy = (state_q == STALL);

`ifdef FWD_STATS_EN
  logic [15:0] fwd_count_q, fwd_count_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [2:0]  fwd_hits;
  logic [16:0] fwd_sum;

  // Forwarded operands are only counted on cycles that issue a real
  // instruction. A bubble cycle carries a NOP, so it is not counted.
  always_comb begin
    fwd_hits = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_sel[i*2 +: 2] != 2'b00) begin
        fwd_hits = fwd_hits + 3'd1;
      end
    end
    fwd_sum       = {1'b0, fwd_count_q} + 17'(fwd_hits);
    fwd_count_d   = fwd_count_q;
    stall_count_d = stall_count_q;
    if (!bubble) begin
      fwd_count_d = fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count_q   <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      fwd_count_q   <= fwd_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_count   = fwd_count_q;
  assign stall_count = stall_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl
//
// Purpose:
//   Self-checking bench for hazard_forward_ctrl, configured with
//   LOAD_STALL_CYC=3 and NUM_SRC=2.
//   - Directed scenarios cover forwarding priority, register zero, stall
//     length, flush and reset.
//   - Randomised traffic follows the directed scenarios.
//   - Expected values come from a reference model. The model tracks the
//     number of stall cycles still owed and applies the forwarding rules
//     operand by operand.
//
// Configuration:
//   FWD_STATS_EN, when defined, also checks the statistics counters.

module tb_hazard_forward_ctrl;

  localparam int RW  = 4;
  localparam int DW  = 16;
  localparam int NS  = 2;
  localparam int LSC = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NS*RW-1:0]  if_id_src_addr;
  logic [NS*RW-1:0]  id_ex_src_addr;
  logic [NS*DW-1:0]  id_ex_src_data;
  logic [RW-1:0]     id_ex_dst_addr;
  logic              id_ex_mem_read;
  logic [RW-1:0]     ex_mem_dst_addr;
  logic              ex_mem_reg_write;
  logic [DW-1:0]     ex_mem_result;
  logic [RW-1:0]     mem_wb_dst_addr;
  logic              mem_wb_reg_write;
  logic [DW-1:0]     mem_wb_data;
  logic [NS*2-1:0]   fwd_sel;
  logic [NS*DW-1:0]  fwd_data;
  logic              stall;
  logic              bubble;
  logic              busy;
`ifdef FWD_STATS_EN
  logic [15:0]       fwd_count;
  logic [15:0]       stall_count;
`endif

  int test_count = 0;
  int fail_count = 0;

  // Reference model state: stall cycles still owed after the current one,
  // plus the expected statistics counters.
  int stall_left = 0;
  int exp_fwd_count = 0;
  int exp_stall_count = 0;

  hazard_forward_ctrl #(
    .REG_ADDR_W(RW), .DATA_W(DW), .NUM_SRC(NS), .LOAD_STALL_CYC(LSC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_id_src_addr(if_id_src_addr), .id_ex_src_addr(id_ex_src_addr),
    .id_ex_src_data(id_ex_src_data), .id_ex_dst_addr(id_ex_dst_addr),
    .id_ex_mem_read(id_ex_mem_read), .ex_mem_dst_addr(ex_mem_dst_addr),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
    .mem_wb_dst_addr(mem_wb_dst_addr), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_data(mem_wb_data), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .stall(stall), .bubble(bubble), .busy(busy)
`ifdef FWD_STATS_EN
    , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs. It is called just after a falling edge.
  task automatic applyStimulus(
      input logic r, input logic fl,
      input logic [RW-1:0] ifs0, input logic [RW-1:0] ifs1,
      input logic [RW-1:0] exs0, input logic [RW-1:0] exs1,
      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
      input logic [RW-1:0] ld_dst, input logic ld,
      input logic [RW-1:0] em_dst, input logic em_we, input logic [DW-1:0] em_res,
      input logic [RW-1:0] mw_dst, input logic mw_we, input logic [DW-1:0] mw_dat);
    rst = r; flush = fl;
    if_id_src_addr = {ifs1, ifs0};
    id_ex_src_addr = {exs1, exs0};
    id_ex_src_data = {d1, d0};
    id_ex_dst_addr = ld_dst; id_ex_mem_read = ld;
    ex_mem_dst_addr = em_dst; ex_mem_reg_write = em_we; ex_mem_result = em_res;
    mem_wb_dst_addr = mw_dst; mem_wb_reg_write = mw_we; mem_wb_data = mw_dat;
  endtask

  // Checks the outputs of the current cycle, advances the model across the
  // next rising edge, and then waits for the following falling edge.
  task automatic stepCycle(input string tag);
    logic          hz;
    logic          exp_stall;
    logic [1:0]    exp_sel;
    logic [DW-1:0] exp_dat;
    logic [RW-1:0] s;
    int            nfwd;
    #1;
    nfwd = 0;
    for (int i = 0; i < NS; i++) begin
      s = id_ex_src_addr[i*RW +: RW];
      if (ex_mem_reg_write && ex_mem_dst_addr != 0 && ex_mem_dst_addr == s) begin
        exp_sel = 2'b10; exp_dat = ex_mem_result;
      end else if (mem_wb_reg_write && mem_wb_dst_addr != 0 && mem_wb_dst_addr == s) begin
        exp_sel = 2'b01; exp_dat = mem_wb_data;
      end else begin
        exp_sel = 2'b00; exp_dat = id_ex_src_data[i*DW +: DW];
      end
      if (exp_sel != 2'b00) nfwd++;
      checkOutput($sformatf("%s sel%0d", tag, i), 32'(fwd_sel[i*2 +: 2]), 32'(exp_sel));
      checkOutput($sformatf("%s data%0d", tag, i), 32'(fwd_data[i*DW +: DW]), 32'(exp_dat));
    end
    hz = 1'b0;
    for (int i = 0; i < NS; i++)
      if (id_ex_mem_read && id_ex_dst_addr != 0 && if_id_src_addr[i*RW +: RW] == id_ex_dst_addr)
        hz = 1'b1;
    exp_stall = !flush && (stall_left > 0 || hz);
    checkOutput({tag, " stall"}, 32'(stall), 32'(exp_stall));
    checkOutput({tag, " bubble"}, 32'(bubble), 32'(exp_stall));
    checkOutput({tag, " busy"}, 32'(busy), 32'(stall_left > 0));
`ifdef FWD_STATS_EN
    checkOutput({tag, " fwd_count"}, 32'(fwd_count), 32'(exp_fwd_count));
    checkOutput({tag, " stall_count"}, 32'(stall_count), 32'(exp_stall_count));
`endif
    if (rst) begin
      stall_left = 0; exp_fwd_count = 0; exp_stall_count = 0;
    end else begin
      if (!exp_stall) exp_fwd_count = (exp_fwd_count + nfwd > 65535) ? 65535 : exp_fwd_count + nfwd;
      if (exp_stall && exp_stall_count < 65535) exp_stall_count++;
      if (flush) stall_left = 0;
      else if (stall_left > 0) stall_left--;
      else if (hz) stall_left = LSC - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("reset_state");

    // EX/MEM writes r3, and operand 0 in EX reads r3.
    applyStimulus(0, 0, 1, 1, 3, 4, 16'h1234, 16'h5678, 0, 0, 3, 1, 16'h00AA, 0, 0, 0);
    stepCycle("t1_exmem_fwd");
    // EX/MEM and MEM/WB both write r5. EX/MEM must win for operand 1.
    applyStimulus(0, 0, 1, 1, 1, 5, 16'h1234, 16'h5678, 0, 0, 5, 1, 16'hBEEF, 5, 1, 16'hCAFE);
    stepCycle("t2_priority");
    // MEM/WB is the only hit.
    applyStimulus(0, 0, 1, 1, 6, 2, 16'h1234, 16'h5678, 0, 0, 5, 1, 16'hBEEF, 6, 1, 16'hCAFE);
    stepCycle("t2b_memwb");
    // Writes to r0 are never forwarded.
    applyStimulus(0, 0, 1, 1, 0, 0, 16'h0A0A, 16'h0B0B, 0, 0, 0, 1, 16'hFFFF, 0, 1, 16'hEEEE);
    stepCycle("t3_r0");

    // Load into r2 in EX, and the instruction in ID reads r2 as operand 1.
    // The bubble then clears the load out of EX.
    applyStimulus(0, 0, 7, 2, 1, 1, 16'h0, 16'h0, 2, 1, 0, 0, 0, 0, 0, 0);
    stepCycle("t4_c1");
    applyStimulus(0, 0, 7, 2, 1, 1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("t4_c2");
    stepCycle("t4_c3");
    stepCycle("t4_c4");

    // Flush arrives in the second stall cycle.
    applyStimulus(0, 0, 2, 7, 1, 1, 16'h0, 16'h0, 2, 1, 0, 0, 0, 0, 0, 0);
    stepCycle("t5_c1");
    applyStimulus(0, 1, 2, 7, 1, 1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("t5_flush");
    applyStimulus(0, 0, 2, 7, 1, 1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("t5_after");

    // Reset is asserted in the middle of STALL.
    applyStimulus(0, 0, 9, 9, 9, 9, 16'h0, 16'h0, 9, 1, 9, 1, 16'h7, 0, 0, 0);
    stepCycle("t6_c1");
    applyStimulus(1, 0, 9, 9, 9, 9, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("t6_rst");
    applyStimulus(0, 0, 9, 9, 9, 9, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("t6_after");

    // Random traffic. Registers are limited to r0..r7 so that hits are
    // frequent, and flush and reset are rare.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(
        ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
        RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
        RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
        DW'($urandom), DW'($urandom),
        RW'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
        RW'($urandom_range(0, 7)), 1'($urandom), DW'($urandom),
        RW'($urandom_range(0, 7)), 1'($urandom), DW'($urandom));
      stepCycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
